// File: rtl/cpu_control.sv
// Fetch/decode/execute sequencer for the 8-bit CPU: drives memory and the
// registered ALU, and keeps the accumulator, program counter and Z/C flags.
module cpu_control #(
  parameter int         ADDR_W = 4,
  parameter logic [2:0] OP_ADD = 3'b000,
  parameter logic [2:0] OP_SUB = 3'b001,
  parameter logic [2:0] OP_AND = 3'b010,
  parameter logic [2:0] OP_OR  = 3'b011
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              alu_en,
  output logic [2:0]        alu_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_out,
  input  logic              alu_carry,
  output logic [7:0]        acc,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_LOAD_IR = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_READ    = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_WB      = 3'd5;
  localparam logic [2:0] S_HALT    = 3'd6;

  localparam logic [3:0] OPC_NOP = 4'h0;
  localparam logic [3:0] OPC_LDA = 4'h1;
  localparam logic [3:0] OPC_ADD = 4'h2;
  localparam logic [3:0] OPC_SUB = 4'h3;
  localparam logic [3:0] OPC_AND = 4'h4;
  localparam logic [3:0] OPC_OR  = 4'h5;
  localparam logic [3:0] OPC_STA = 4'h6;
  localparam logic [3:0] OPC_JMP = 4'h7;
  localparam logic [3:0] OPC_JZ  = 4'h8;
  localparam logic [3:0] OPC_JC  = 4'h9;
  localparam logic [3:0] OPC_HLT = 4'hF;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        opr_q, opr_d;
  logic [7:0]        acc_q, acc_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic              is_alu_op;

  assign opcode    = ir_q[7:4];
  assign ir_addr   = ADDR_W'(ir_q[3:0]);
  assign is_alu_op = (opcode == OPC_ADD) || (opcode == OPC_SUB) ||
                     (opcode == OPC_AND) || (opcode == OPC_OR);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    opr_d    = opr_q;
    acc_d    = acc_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;

    case (state_q)
      S_FETCH: begin
        state_d = S_LOAD_IR;
      end

      S_LOAD_IR: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end

      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode)
          OPC_HLT: state_d = S_HALT;
          OPC_JMP: pc_d = ir_addr;
          OPC_JZ:  if (flag_z_q) pc_d = ir_addr;
          OPC_JC:  if (flag_c_q) pc_d = ir_addr;
          OPC_LDA, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: state_d = S_READ;
          default: state_d = S_FETCH;
        endcase
      end

      S_READ: begin
        if (is_alu_op) begin
          opr_d   = mem_rdata;
          state_d = S_EXEC;
        end else begin
          // LDA leaves the carry flag alone
          acc_d    = mem_rdata;
          flag_z_d = (mem_rdata == 8'h00);
          state_d  = S_FETCH;
        end
      end

      S_EXEC: begin
        state_d = S_WB;
      end

      S_WB: begin
        acc_d    = alu_out;
        flag_z_d = (alu_out == 8'h00);
        flag_c_d = alu_carry;
        state_d  = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      opr_q    <= '0;
      acc_q    <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      opr_q    <= opr_d;
      acc_q    <= acc_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  // Moore outputs: DECODE addresses the operand, every other state the pc
  always_comb begin
    mem_addr = (state_q == S_DECODE) ? ir_addr : pc_q;
    mem_we   = (state_q == S_DECODE) && (opcode == OPC_STA);
    alu_en   = (state_q == S_EXEC);
    halted   = (state_q == S_HALT);
    case (opcode)
      OPC_SUB: alu_op = OP_SUB;
      OPC_AND: alu_op = OP_AND;
      OPC_OR:  alu_op = OP_OR;
      default: alu_op = OP_ADD;
    endcase
  end

  assign mem_wdata = acc_q;
  assign alu_a     = acc_q;
  assign alu_b     = opr_q;
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;

endmodule
